// File: rtl/xadc_pkg.sv
// Shared XADC DRP definitions: bus widths, well-known addresses and
// the arbiter state encoding.
package xadc_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    localparam logic [DRP_ADDR_W-1:0] AUX_STATUS_BASE = 7'h10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

endpackage

// File: rtl/xadc_drp_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward
// from last_grant+1 with wrap-around.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last_grant,
    output logic         found,
    output logic [2:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Descending offsets so the nearest candidate is written last.
        for (int i = N; i >= 1; i--) begin
            for (int j = 0; j < N; j++) begin
                if ((j == ((int'(last_grant) + i) % N)) && req[j]) begin
                    found = 1'b1;
                    idx   = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing the XADC DRP port between N_REQ requesters,
// one DRP transaction per grant with a DRDY timeout.
module xadc_drp_arbiter
    import xadc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_REQ-1:0]                      req,
    input  logic [N_REQ-1:0]                      req_we,
    input  logic [N_REQ-1:0][DRP_ADDR_W-1:0]      req_addr,
    input  logic [N_REQ-1:0][DRP_DATA_W-1:0]      req_wdata,
    output logic [N_REQ-1:0]                      ack,
    output logic                                  err,
    output logic [DRP_DATA_W-1:0]                 rdata,
    output logic                                  busy,
    output logic [2:0]                            grant_idx,
    output logic [DRP_ADDR_W-1:0]                 drp_addr,
    output logic                                  drp_en,
    output logic                                  drp_we,
    output logic [DRP_DATA_W-1:0]                 drp_di,
    input  logic [DRP_DATA_W-1:0]                 drp_do,
    input  logic                                  drp_drdy
);

    arb_state_e              state_q, state_d;
    logic [2:0]              grant_q, grant_d;
    logic [2:0]              last_q, last_d;
    logic [DRP_ADDR_W-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DRP_DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [DRP_DATA_W-1:0]   rdata_q, rdata_d;

    logic                    pick_found;
    logic [2:0]              pick_idx;
    logic [DRP_ADDR_W-1:0]   sel_addr;
    logic                    sel_we;
    logic [DRP_DATA_W-1:0]   sel_wdata;

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req        (req),
        .last_grant (last_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == 3'(i)) begin
                sel_addr  = req_addr[i];
                sel_we    = req_we[i];
                sel_wdata = req_wdata[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'(TIMEOUT);
                state_d = WAIT;
            end
            WAIT: begin
                // DRDY takes precedence over an expiring counter.
                if (drp_drdy) begin
                    rdata_d = we_q ? '0 : drp_do;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 8'd0) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 3'(N_REQ - 1);
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (state_q == DONE) && (grant_q == 3'(i));
        end
    end

    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign drp_en    = (state_q == ISSUE);
    assign drp_we    = drp_en & we_q;
    assign drp_addr  = drp_en ? addr_q : '0;
    assign drp_di    = drp_en ? wdata_q : '0;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter with a small XADC DRDY model.
module tb_xadc_drp_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0]       req_we = '0;
    logic [3:0][6:0]  req_addr = '0;
    logic [3:0][15:0] req_wdata = '0;
    logic [3:0]       ack;
    logic             err;
    logic [15:0]      rdata;
    logic             busy;
    logic [2:0]       grant_idx;
    logic [6:0]       drp_addr;
    logic             drp_en;
    logic             drp_we;
    logic [15:0]      drp_di;
    logic [15:0]      drp_do = '0;
    logic             drp_drdy;

    logic             mdl_drdy = 1'b0;
    logic             extra_drdy = 1'b0;
    int               mdl_dly = 1;
    int               mdl_left = 0;

    int n_chk = 0;
    int n_fail = 0;

    assign drp_drdy = mdl_drdy | extra_drdy;

    xadc_drp_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .grant_idx (grant_idx),
        .drp_addr  (drp_addr),
        .drp_en    (drp_en),
        .drp_we    (drp_we),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy)
    );

    always #5 clk = ~clk;

    // XADC model: DRDY for one cycle, mdl_dly cycles after the DEN cycle.
    always @(negedge clk) begin
        mdl_drdy = 1'b0;
        if (drp_en) begin
            mdl_left = mdl_dly;
        end else if (mdl_left > 0) begin
            mdl_left = mdl_left - 1;
            mdl_drdy = (mdl_left == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input int idx, input logic we, input logic [6:0] a,
                       input logic [15:0] wd, output int lat,
                       output logic [3:0] ak, output logic e,
                       output logic [15:0] rd);
        lat = 0;
        ak  = '0;
        e   = 1'b0;
        rd  = '0;
        @(posedge clk); #1;
        req            = '0;
        req[idx]       = 1'b1;
        req_we[idx]    = we;
        req_addr[idx]  = a;
        req_wdata[idx] = wd;
        @(posedge clk); #1;
        req[idx] = 1'b0;
        @(negedge clk);
        chk("den_c1", {31'd0, drp_en}, 32'd1);
        chk("daddr", {25'd0, drp_addr}, {25'd0, a});
        chk("dwe", {31'd0, drp_we}, {31'd0, we});
        chk("ddi", {16'd0, drp_di}, we ? {16'd0, wd} : 32'd0);
        for (int c = 2; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) chk("den_c2", {31'd0, drp_en}, 32'd0);
            if (ack != 4'd0) begin
                lat = c;
                ak  = ack;
                e   = err;
                rd  = rdata;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [3:0]  ak;
        logic        e;
        logic [15:0] rd;
        int          got_n;
        logic [3:0]  order [8];

        #1;
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_out", {err, busy, grant_idx, drp_en, drp_we}, 32'd0);
        chk("rst_bus", {rdata, 9'd0, drp_addr}, 32'd0);
        chk("rst_di", {16'd0, drp_di}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single read, DRDY 2 cycles after DEN.
        mdl_dly = 2;
        drp_do  = 16'hABCD;
        txn(0, 1'b0, 7'h13, 16'h0000, lat, ak, e, rd);
        chk("rd_lat", lat, 4);
        chk("rd_ack", {28'd0, ak}, 32'h1);
        chk("rd_err", {31'd0, e}, 32'd0);
        chk("rd_data", {16'd0, rd}, 32'hABCD);

        // Write: rdata must be 0 even though DO carries data.
        mdl_dly = 1;
        txn(2, 1'b1, 7'h41, 16'h2FF0, lat, ak, e, rd);
        chk("wr_lat", lat, 3);
        chk("wr_ack", {28'd0, ak}, 32'h4);
        chk("wr_err", {31'd0, e}, 32'd0);
        chk("wr_data", {16'd0, rd}, 32'd0);

        // Timeout with TIMEOUT=4, no DRDY.
        mdl_dly = 0;
        txn(1, 1'b0, 7'h20, 16'h0000, lat, ak, e, rd);
        chk("to_lat", lat, 7);
        chk("to_ack", {28'd0, ak}, 32'h2);
        chk("to_err", {31'd0, e}, 32'd1);
        chk("to_data", {16'd0, rd}, 32'd0);
        extra_drdy = 1'b1;
        @(negedge clk);
        extra_drdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("late_ack", {28'd0, ack}, 32'd0);
            chk("late_busy", {31'd0, busy}, 32'd0);
        end
        chk("late_err", {31'd0, err}, 32'd1);

        // DRDY coincident with counter reaching zero.
        mdl_dly = 5;
        drp_do  = 16'h1234;
        txn(3, 1'b0, 7'h05, 16'h0000, lat, ak, e, rd);
        chk("col_lat", lat, 7);
        chk("col_ack", {28'd0, ak}, 32'h8);
        chk("col_err", {31'd0, e}, 32'd0);
        chk("col_data", {16'd0, rd}, 32'h1234);

        // Round-robin with all four requesting; last grant was 3.
        mdl_dly = 1;
        @(posedge clk); #1;
        req_we   = '0;
        req_addr = {7'h33, 7'h22, 7'h11, 7'h00};
        req      = 4'b1111;
        got_n    = 0;
        for (int c = 0; c < 80 && got_n < 8; c++) begin
            @(negedge clk);
            if (ack != 4'd0) begin
                chk("rr_onehot", $countones(ack), 1);
                order[got_n] = ack;
                got_n++;
            end
        end
        req = '0;
        chk("rr_count", got_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_order%0d", i), {28'd0, order[i]},
                32'd1 << (i % 4));
        end

        // Complete one on requester 1, then abort one on 2 with reset.
        txn(1, 1'b0, 7'h11, 16'h0000, lat, ak, e, rd);
        chk("pre_ack", {28'd0, ak}, 32'h2);
        mdl_dly = 0;
        @(posedge clk); #1;
        req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_out", {ack, err, busy, grant_idx, drp_en}, 32'd0);
        chk("mr_bus", {rdata, 9'd0, drp_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mdl_dly = 1;
        @(posedge clk); #1;
        req = 4'b1111;
        ak  = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != 4'd0) begin
                ak = ack;
                break;
            end
        end
        req = '0;
        chk("post_rst_grant", {28'd0, ak}, 32'h1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
